// File: rtl/arth_pkg.sv
// Shared constants for the arithmetic-unit sequencer: opcodes, FSM encoding, settle default.
package arth_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_BAD = 2'b11;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam int SETTLE_CYC_DEF = 2;

endpackage

// File: rtl/arth_rr_arbiter.sv
// 2-way request arbiter. ARTH_SEQ_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module arth_rr_arbiter (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       grant_valid,
   output logic       gid
);

   assign grant_valid = |req;

`ifdef ARTH_SEQ_RR_EN
   logic ptr_q;  // requester that wins a tie

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                      ptr_q <= 1'b0;
      else if (advance && grant_valid) ptr_q <= ~gid;
   end

   always_comb begin
      if (req[0] && req[1]) gid = ptr_q;
      else                  gid = req[1];
   end
`else
   logic unused_ok;
   assign unused_ok = ^{clock, reset, advance};
   assign gid       = ~req[0] & req[1];
`endif

endmodule

// File: rtl/arth_sequencer.sv
// Two-requester sequencer owning the 4-bit arithmetic unit (opcode load, precharge, execute, ack).
// Build option: ARTH_SEQ_RR_EN enables round-robin arbitration in arth_rr_arbiter.
module arth_sequencer
   import arth_pkg::*;
#(
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [1:0]  op0,
   input  logic [1:0]  op1,
   input  logic [3:0]  a0,
   input  logic [3:0]  b0,
   input  logic [3:0]  a1,
   input  logic [3:0]  b1,
   output logic        ack0,
   output logic        ack1,
   output logic [15:0] result,
   output logic        err,
   output logic        busy,
   output logic [3:0]  au_v1,
   output logic [3:0]  au_v2,
   output logic [1:0]  au_opcode,
   output logic        au_newop,
   input  logic [15:0] au_ans
);

   localparam int CW = $clog2(SETTLE_CYC + 1);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          gid_q, err_q, last_vld_q;
   logic [1:0]    op_q, opc_q, last_op_q;
   logic [3:0]    a_q, b_q, v1_q, v2_q;
   logic [15:0]   result_q;
   logic          grant_valid, gnt_id, advance;
   logic [1:0]    sel_op;

   arth_rr_arbiter u_arb (
      .clock       (clock),
      .reset       (reset),
      .req         ({req1, req0}),
      .advance     (advance),
      .grant_valid (grant_valid),
      .gid         (gnt_id)
   );

   assign advance = (state_q == ST_IDLE) && grant_valid;
   assign sel_op  = gnt_id ? op1 : op0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               if (sel_op == OP_BAD) begin
                  state_d = ST_DONE;
               end else if (last_vld_q && (sel_op == last_op_q)) begin
                  state_d = ST_SETTLE;
                  cnt_d   = CW'(1);
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            state_d = ST_SETTLE;
            cnt_d   = CW'(SETTLE_CYC);
         end
         ST_SETTLE: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = ST_EXEC;
         end
         ST_EXEC: state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         gid_q      <= 1'b0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         opc_q      <= '0;
         last_op_q  <= '0;
         last_vld_q <= 1'b0;
         v1_q       <= '0;
         v2_q       <= '0;
         result_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         case (state_q)
            ST_IDLE: begin
               if (grant_valid) begin
                  gid_q <= gnt_id;
                  op_q  <= sel_op;
                  a_q   <= gnt_id ? a1 : a0;
                  b_q   <= gnt_id ? b1 : b0;
                  err_q <= (sel_op == OP_BAD);
                  if (sel_op == OP_BAD) result_q <= '0;
               end
            end
            ST_LOAD: begin
               opc_q      <= op_q;
               last_op_q  <= op_q;
               last_vld_q <= 1'b1;
            end
            ST_EXEC: begin
               result_q <= au_ans;
               v1_q     <= a_q;
               v2_q     <= b_q;
            end
            default: ;
         endcase
      end
   end

   // Inverted operands in SETTLE guarantee the unit sees an operand change in EXEC.
   assign au_v1     = (state_q == ST_SETTLE) ? ~a_q : (state_q == ST_EXEC) ? a_q : v1_q;
   assign au_v2     = (state_q == ST_SETTLE) ? ~b_q : (state_q == ST_EXEC) ? b_q : v2_q;
   assign au_opcode = (state_q == ST_LOAD) ? op_q : opc_q;
   assign au_newop  = (state_q == ST_LOAD);
   assign busy      = (state_q != ST_IDLE);
   assign ack0      = (state_q == ST_DONE) && !gid_q;
   assign ack1      = (state_q == ST_DONE) &&  gid_q;
   assign result    = result_q;
   assign err       = err_q;

endmodule

// File: tb/tb_arth_sequencer.sv
// Scoreboard bench for arth_sequencer with a behavioural model of the arithmetic unit.
module tb_arth_sequencer;
   import arth_pkg::*;

   logic        clock, reset, req0, req1;
   logic [1:0]  op0, op1;
   logic [3:0]  a0, b0, a1, b1;
   logic        ack0, ack1, err, busy, au_newop;
   logic [15:0] result, au_ans;
   logic [3:0]  au_v1, au_v2;
   logic [1:0]  au_opcode;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      bit          gid;
      logic [15:0] res;
      bit          err;
   } exp_t;
   exp_t sb_q[$];

   arth_sequencer dut (
      .clock(clock), .reset(reset), .req0(req0), .req1(req1),
      .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .ack0(ack0), .ack1(ack1), .result(result), .err(err), .busy(busy),
      .au_v1(au_v1), .au_v2(au_v2), .au_opcode(au_opcode), .au_newop(au_newop),
      .au_ans(au_ans)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Arithmetic unit: two-stage opcode register; answer re-evaluates only on operand change.
   logic [1:0] u_st1, u_act;
   always @(posedge clock) begin
      if (au_newop) u_st1 <= au_opcode;
      u_act <= u_st1;
   end

   function automatic logic [15:0] unit_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] s;
      s = {1'b0, a} + {1'b0, b};
      case (op)
         OP_ADD:  return {{11{s[4]}}, s};
         OP_MUL:  return 16'(a) * 16'(b);
         OP_SUB:  return 16'(b) - 16'(a);
         default: return 16'd0;
      endcase
   endfunction

   always @(au_v1 or au_v2) au_ans = unit_f(u_act, au_v1, au_v2);

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Monitor: pops an expectation on every ack.
   bit prev_newop = 1'b0;
   always @(negedge clock) begin
      if (ack0 || ack1) begin
         exp_t e;
         chk("ack_onehot", {31'd0, ack0 && ack1}, 32'd0);
         if (sb_q.size() == 0) begin
            chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("ack_gid", {31'd0, ack1}, {31'd0, e.gid});
            chk("result", {16'd0, result}, {16'd0, e.res});
            chk("err", {31'd0, err}, {31'd0, e.err});
         end
      end
      if (au_newop) chk("newop_single", {31'd0, prev_newop}, 32'd0);
      prev_newop = au_newop;
   end

   function automatic logic [31:0] all_out();
      return {1'b0, ack0, ack1, result, err, busy, au_v1, au_v2, au_opcode, au_newop};
   endfunction

   task automatic do_op(input bit r, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [15:0] exp_res, input bit exp_err, input int exp_lat, input int exp_nop);
      int  nop;
      bit  seen;
      exp_t e;
      @(posedge clock); #1;
      if (r) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
      else   begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
      e.gid = r; e.res = exp_res; e.err = exp_err;
      sb_q.push_back(e);
      nop  = 0;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clock);
         if (au_newop) nop++;
         if (r ? ack1 : ack0) begin
            seen = 1'b1;
            chk("latency", k, exp_lat);
         end
      end
      if (!seen) chk("ack_timeout", 32'd0, 32'd1);
      chk("newop_count", nop, exp_nop);
      @(posedge clock); #1;
      if (r) req1 = 1'b0; else req0 = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   initial begin
      int nack;
      exp_t e;
      reset = 1'b0; req0 = 0; req1 = 0;
      op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      @(negedge clock);
      chk("reset_outputs", all_out(), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("idle_outputs", all_out(), 32'd0);

      do_op(1'b0, OP_ADD, 4'd3,  4'd5,  16'd8,   1'b0, 5, 1);
      do_op(1'b0, OP_ADD, 4'd3,  4'd5,  16'd8,   1'b0, 3, 0);
      do_op(1'b1, OP_MUL, 4'd15, 4'd15, 16'd225, 1'b0, 5, 1);
      do_op(1'b1, OP_SUB, 4'd2,  4'd7,  16'd5,   1'b0, 5, 1);
      do_op(1'b0, OP_BAD, 4'd9,  4'd9,  16'd0,   1'b1, 1, 0);
      chk("bad_v1_held", {28'd0, au_v1}, 32'd2);
      chk("bad_v2_held", {28'd0, au_v2}, 32'd7);
      chk("bad_opc_held", {30'd0, au_opcode}, {30'd0, OP_SUB});

      // Reset during SETTLE of a repeated-opcode operation.
      @(posedge clock); #1;
      req0 = 1'b1; op0 = OP_SUB; a0 = 4'd2; b0 = 4'd7;
      @(negedge clock);
      @(negedge clock);
      chk("settle_busy", {31'd0, busy}, 32'd1);
      chk("settle_precharge", {28'd0, au_v1}, 32'hd);
      reset = 1'b0;
      #1;
      chk("midop_reset_outputs", all_out(), 32'd0);
      req0 = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("post_reset_idle", all_out(), 32'd0);
      do_op(1'b0, OP_SUB, 4'd2, 4'd7, 16'd5, 1'b0, 5, 1);

      // Both requesters held continuously.
      pulse_reset();
      @(posedge clock); #1;
      req0 = 1'b1; op0 = OP_ADD; a0 = 4'd3;  b0 = 4'd5;
      req1 = 1'b1; op1 = OP_MUL; a1 = 4'd15; b1 = 4'd15;
      for (int i = 0; i < 4; i++) begin
`ifdef ARTH_SEQ_RR_EN
         e.gid = i[0]; e.res = i[0] ? 16'd225 : 16'd8; e.err = 1'b0;
`else
         e.gid = 1'b0; e.res = 16'd8; e.err = 1'b0;
`endif
         sb_q.push_back(e);
      end
      nack = 0;
      for (int k = 0; k < 60 && nack < 4; k++) begin
         @(negedge clock);
         if (ack0 || ack1) nack++;
      end
      chk("contention_acks", nack, 32'd4);
      @(posedge clock); #1;
      req0 = 1'b0; req1 = 1'b0;
      repeat (8) @(negedge clock);
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
